// File: rtl/fwd_pipe_core.sv
// Four-stage ID/EX/MEM/WB integer pipeline with internal register file, valid/ready intake
// and multi-cycle MUL. Define PIPE_FWD_EN for operand forwarding; otherwise a RAW interlock.
module fwd_pipe_core #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NREGS     = 4,
   parameter int unsigned REG_AW    = $clog2(NREGS),
   parameter int unsigned MUL_LAT   = 3,
   parameter int unsigned RESET_VAL = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic [3+3*REG_AW-1:0] instr_i,
   output logic                  wb_valid_o,
   output logic [REG_AW-1:0]     wb_rd_o,
   output logic [DATA_W-1:0]     wb_data_o,
   input  logic [REG_AW-1:0]     dbg_rsel_i,
   output logic [DATA_W-1:0]     dbg_rdata_o,
   output logic                  busy_o
);

   localparam int unsigned IW   = 3 + 3 * REG_AW;
   localparam int unsigned CntW = $clog2(MUL_LAT + 1);

   localparam logic [2:0] OpNop = 3'b000;
   localparam logic [2:0] OpAdd = 3'b001;
   localparam logic [2:0] OpSub = 3'b010;
   localparam logic [2:0] OpInc = 3'b011;
   localparam logic [2:0] OpAnd = 3'b100;
   localparam logic [2:0] OpOr  = 3'b101;
   localparam logic [2:0] OpXor = 3'b110;
   localparam logic [2:0] OpMul = 3'b111;

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StMulBusy = 1'b1;

`ifdef PIPE_FWD_EN
   localparam bit FwdEn = 1'b1;
`else
   localparam bit FwdEn = 1'b0;
`endif

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [2:0]        op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } ex_t;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } res_t;

   function automatic logic hit(input res_t r, input logic [REG_AW-1:0] rs);
      return r.valid && r.we && (r.rd == rs);
   endfunction

   logic [DATA_W-1:0] rf_q [NREGS];
   logic              id_valid_q, id_valid_d;
   logic [IW-1:0]     id_instr_q, id_instr_d;
   ex_t               ex_q, ex_d;
   res_t              mem_q, mem_d, wb_q;
   logic [0:0]        st_q, st_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [2:0]        id_op;
   logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
   logic              id_use1, id_use2, raw1, raw2, hazard;
   logic [DATA_W-1:0] id_a, id_b, ex_a, ex_b, ex_res;
   logic              ex_is_mul, mul_stall, id_hold;

   // ID: operand read; with forwarding the WB write is bypassed so RF is never stale
   assign {id_op, id_rd, id_rs1, id_rs2} = id_instr_q;
   assign id_use1 = (id_op != OpNop);
   assign id_use2 = id_use1 && (id_op != OpInc);
   assign id_a    = (FwdEn && hit(wb_q, id_rs1)) ? wb_q.data : rf_q[id_rs1];
   assign id_b    = (FwdEn && hit(wb_q, id_rs2)) ? wb_q.data : rf_q[id_rs2];

   assign raw1 = (ex_q.valid && ex_q.we && (ex_q.rd == id_rs1)) || hit(mem_q, id_rs1)
                 || hit(wb_q, id_rs1);
   assign raw2 = (ex_q.valid && ex_q.we && (ex_q.rd == id_rs2)) || hit(mem_q, id_rs2)
                 || hit(wb_q, id_rs2);
   assign hazard = !FwdEn && id_valid_q && ((id_use1 && raw1) || (id_use2 && raw2));

   // EX operands: youngest producer (EX/MEM) wins over MEM/WB
   assign ex_a = (FwdEn && hit(mem_q, ex_q.rs1)) ? mem_q.data :
                 (FwdEn && hit(wb_q, ex_q.rs1))  ? wb_q.data  : ex_q.a;
   assign ex_b = (FwdEn && hit(mem_q, ex_q.rs2)) ? mem_q.data :
                 (FwdEn && hit(wb_q, ex_q.rs2))  ? wb_q.data  : ex_q.b;

   always_comb begin
      ex_res = '0;
      case (ex_q.op)
         OpAdd:   ex_res = ex_a + ex_b;
         OpSub:   ex_res = ex_a - ex_b;
         OpInc:   ex_res = ex_a + DATA_W'(1);
         OpAnd:   ex_res = ex_a & ex_b;
         OpOr:    ex_res = ex_a | ex_b;
         OpXor:   ex_res = ex_a ^ ex_b;
         OpMul:   ex_res = ex_a * ex_b;
         default: ex_res = '0;
      endcase
   end

   // MUL occupies EX for MUL_LAT cycles: the entry cycle plus MUL_LAT-1 counted cycles
   assign ex_is_mul = ex_q.valid && (ex_q.op == OpMul);

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      mul_stall = 1'b0;
      case (st_q)
         StIdle: begin
            if (ex_is_mul && (MUL_LAT > 1)) begin
               st_d      = StMulBusy;
               cnt_d     = CntW'(MUL_LAT - 1);
               mul_stall = 1'b1;
            end
         end
         StMulBusy: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               st_d = StIdle;
            end else begin
               mul_stall = 1'b1;
            end
         end
         default: st_d = StIdle;
      endcase
   end

   assign id_hold       = mul_stall || hazard;
   assign instr_ready_o = !id_hold;

   always_comb begin
      id_valid_d = id_valid_q;
      id_instr_d = id_instr_q;
      if (!id_hold) begin
         id_valid_d = instr_valid_i;
         if (instr_valid_i) begin
            id_instr_d = instr_i;
         end
      end

      ex_d = ex_q;
      if (mul_stall) begin
         // Re-latch forwarded operands so they survive producers draining past WB
         ex_d.a = ex_a;
         ex_d.b = ex_b;
      end else if (hazard) begin
         ex_d.valid = 1'b0;
      end else begin
         ex_d.valid = id_valid_q;
         ex_d.we    = (id_op != OpNop);
         ex_d.op    = id_op;
         ex_d.rd    = id_rd;
         ex_d.rs1   = id_rs1;
         ex_d.rs2   = id_rs2;
         ex_d.a     = id_a;
         ex_d.b     = id_b;
      end

      mem_d       = mem_q;
      mem_d.valid = 1'b0;
      if (!mul_stall) begin
         mem_d.valid = ex_q.valid;
         mem_d.we    = ex_q.we;
         mem_d.rd    = ex_q.rd;
         mem_d.data  = ex_res;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         id_valid_q <= 1'b0;
         id_instr_q <= '0;
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         st_q       <= StIdle;
         cnt_q      <= '0;
      end else begin
         id_valid_q <= id_valid_d;
         id_instr_q <= id_instr_d;
         ex_q       <= ex_d;
         mem_q      <= mem_d;
         wb_q       <= mem_q;
         st_q       <= st_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rf_q <= '{default: DATA_W'(RESET_VAL)};
      end else if (wb_q.valid && wb_q.we) begin
         rf_q[wb_q.rd] <= wb_q.data;
      end
   end

   assign wb_valid_o  = wb_q.valid && wb_q.we;
   assign wb_rd_o     = wb_q.rd;
   assign wb_data_o   = wb_q.data;
   assign dbg_rdata_o = rf_q[dbg_rsel_i];
   assign busy_o      = id_valid_q || ex_q.valid || mem_q.valid || wb_q.valid;

endmodule
